// File: rtl/mem_pkg.sv
// Shared definitions for the MEM-stage data-memory access unit: op encodings,
// default address limit and fault-FSM state codes.
package mem_pkg;

  localparam logic [3:0] MEM_NONE = 4'd0;
  localparam logic [3:0] MEM_LW   = 4'd1;
  localparam logic [3:0] MEM_LH   = 4'd2;
  localparam logic [3:0] MEM_LHU  = 4'd3;
  localparam logic [3:0] MEM_LB   = 4'd4;
  localparam logic [3:0] MEM_LBU  = 4'd5;
  localparam logic [3:0] MEM_SW   = 4'd6;
  localparam logic [3:0] MEM_SH   = 4'd7;
  localparam logic [3:0] MEM_SB   = 4'd8;

  // First illegal byte address: 2^20 words of data memory.
  localparam logic [31:0] ADDR_LIMIT_DEFAULT = 32'h0040_0000;

  localparam logic [0:0] ERR_IDLE     = 1'b0;
  localparam logic [0:0] ERR_CAPTURED = 1'b1;

  function automatic logic is_load(input logic [3:0] op);
    return (op == MEM_LW) || (op == MEM_LH) || (op == MEM_LHU) ||
           (op == MEM_LB) || (op == MEM_LBU);
  endfunction

  function automatic logic is_store(input logic [3:0] op);
    return (op == MEM_SW) || (op == MEM_SH) || (op == MEM_SB);
  endfunction

endpackage

// File: rtl/mem_align.sv
// Combinational datapath: alignment/range check, sub-word store merge into the
// read word, and load extraction with sign/zero extension.
module mem_align
  import mem_pkg::*;
#(
  parameter logic [31:0] ADDR_LIMIT = ADDR_LIMIT_DEFAULT
) (
  input  logic [3:0]  op,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic        fault_cond,
  output logic [31:0] wd,
  output logic [31:0] ld_data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    fault_cond = 1'b0;
    case (op)
      MEM_LW, MEM_SW:          fault_cond = (addr[1:0] != 2'b00);
      MEM_LH, MEM_LHU, MEM_SH: fault_cond = addr[0];
      default:                 fault_cond = 1'b0;
    endcase
    if ((is_load(op) || is_store(op)) && (addr >= ADDR_LIMIT)) begin
      fault_cond = 1'b1;
    end
  end

  always_comb begin
    byte_sel = rdata[7:0];
    case (addr[1:0])
      2'd0: byte_sel = rdata[7:0];
      2'd1: byte_sel = rdata[15:8];
      2'd2: byte_sel = rdata[23:16];
      2'd3: byte_sel = rdata[31:24];
      default: byte_sel = rdata[7:0];
    endcase
    half_sel = addr[1] ? rdata[31:16] : rdata[15:0];
  end

  // Sub-word stores are read-modify-write against the current memory word.
  always_comb begin
    wd = rdata;
    case (op)
      MEM_SW: wd = wdata;
      MEM_SH: wd = addr[1] ? {wdata[15:0], rdata[15:0]} : {rdata[31:16], wdata[15:0]};
      MEM_SB: begin
        case (addr[1:0])
          2'd0: wd = {rdata[31:8], wdata[7:0]};
          2'd1: wd = {rdata[31:16], wdata[7:0], rdata[7:0]};
          2'd2: wd = {rdata[31:24], wdata[7:0], rdata[15:0]};
          2'd3: wd = {wdata[7:0], rdata[23:0]};
          default: wd = rdata;
        endcase
      end
      default: wd = rdata;
    endcase
  end

  always_comb begin
    ld_data = 32'h0;
    case (op)
      MEM_LW:  ld_data = rdata;
      MEM_LH:  ld_data = {{16{half_sel[15]}}, half_sel};
      MEM_LHU: ld_data = {16'h0, half_sel};
      MEM_LB:  ld_data = {{24{byte_sel[7]}}, byte_sel};
      MEM_LBU: ld_data = {24'h0, byte_sel};
      default: ld_data = 32'h0;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage controller: drives the data-memory port, owns the MEM/WB register
// and the first-fault capture FSM with a saturating fault counter.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter logic [31:0] ADDR_LIMIT = ADDR_LIMIT_DEFAULT,
  parameter int          ERR_CNT_W  = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req_valid,
  input  logic [3:0]           req_op,
  input  logic [31:0]          req_addr,
  input  logic [31:0]          req_wdata,
  input  logic [31:0]          req_pc,
  input  logic [4:0]           req_rd,
  input  logic                 stall,
  input  logic                 flush,
  input  logic                 err_clr,
  output logic [31:0]          dm_a,
  output logic [31:0]          dm_wd,
  output logic                 dm_we,
  output logic [31:0]          dm_pc,
  input  logic [31:0]          dm_rd,
  output logic                 wb_valid,
  output logic [4:0]           wb_rd,
  output logic [31:0]          wb_data,
  output logic [31:0]          wb_pc,
  output logic                 err_valid,
  output logic [31:0]          err_pc,
  output logic [31:0]          err_badaddr,
  output logic                 err_store,
  output logic [ERR_CNT_W-1:0] err_count
);

  logic        fault_cond;
  logic [31:0] ld_data;
  logic        op_load;
  logic        op_store;
  logic        fault;
  logic        advance;
  logic        counted_fault;
  logic [0:0]  err_state;

  mem_align #(.ADDR_LIMIT(ADDR_LIMIT)) u_align (
    .op         (req_op),
    .addr       (req_addr),
    .wdata      (req_wdata),
    .rdata      (dm_rd),
    .fault_cond (fault_cond),
    .wd         (dm_wd),
    .ld_data    (ld_data)
  );

  // A request advances when it is neither stalled nor flushed; only an
  // advancing request writes memory, counts a fault or fills MEM/WB.
  always_comb begin
    op_load       = is_load(req_op);
    op_store      = is_store(req_op);
    fault         = req_valid & (op_load | op_store) & fault_cond;
    advance       = ~stall & ~flush;
    counted_fault = fault & advance;
    dm_we         = req_valid & op_store & ~fault & advance & reset;
    dm_a          = {req_addr[31:2], 2'b00};
    dm_pc         = req_pc;
    err_valid     = (err_state == ERR_CAPTURED);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wb_valid <= 1'b0;
      wb_rd    <= 5'd0;
      wb_data  <= 32'h0;
      wb_pc    <= 32'h0;
    end else if (flush) begin
      wb_valid <= 1'b0;
      wb_rd    <= 5'd0;
      wb_data  <= 32'h0;
      wb_pc    <= req_pc;
    end else if (!stall) begin
      wb_valid <= req_valid & (op_load | op_store);
      wb_rd    <= (req_valid & op_load & ~fault) ? req_rd : 5'd0;
      wb_data  <= (req_valid & op_load) ? ld_data : 32'h0;
      wb_pc    <= req_pc;
    end
  end

  // A new fault in the same cycle as err_clr wins over the clear.
  always_ff @(posedge clk) begin
    if (!reset) begin
      err_state   <= ERR_IDLE;
      err_pc      <= 32'h0;
      err_badaddr <= 32'h0;
      err_store   <= 1'b0;
    end else if (counted_fault && (err_state == ERR_IDLE || err_clr)) begin
      err_state   <= ERR_CAPTURED;
      err_pc      <= req_pc;
      err_badaddr <= req_addr;
      err_store   <= op_store;
    end else if (err_clr) begin
      err_state   <= ERR_IDLE;
      err_pc      <= 32'h0;
      err_badaddr <= 32'h0;
      err_store   <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      err_count <= '0;
    end else if (counted_fault && (err_count != {ERR_CNT_W{1'b1}})) begin
      err_count <= err_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a small word-addressed memory model.
module tb_mem_access_unit;
  import mem_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic [3:0]  req_op;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [31:0] req_pc;
  logic [4:0]  req_rd;
  logic        stall;
  logic        flush;
  logic        err_clr;
  logic [31:0] dm_a;
  logic [31:0] dm_wd;
  logic        dm_we;
  logic [31:0] dm_pc;
  logic [31:0] dm_rd;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic [31:0] wb_pc;
  logic        err_valid;
  logic [31:0] err_pc;
  logic [31:0] err_badaddr;
  logic        err_store;
  logic [7:0]  err_count;

  int total = 0;
  int bad   = 0;
  int we_count = 0;

  logic [31:0] mem [0:4095];

  logic [3:0]  ld_op   [0:7] = '{MEM_LB, MEM_LB, MEM_LBU, MEM_LH, MEM_LHU, MEM_LW, MEM_LH, MEM_LBU};
  logic [31:0] ld_addr [0:7] = '{32'h2000, 32'h2001, 32'h2001, 32'h2002, 32'h2002, 32'h2000, 32'h2000, 32'h2003};
  logic [31:0] ld_exp  [0:7] = '{32'h0000_007F, 32'hFFFF_FFFF, 32'h0000_00FF, 32'hFFFF_8000,
                                 32'h0000_8000, 32'h8000_FF7F, 32'hFFFF_FF7F, 32'h0000_0080};

  mem_access_unit dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_op(req_op),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_pc(req_pc), .req_rd(req_rd),
    .stall(stall), .flush(flush), .err_clr(err_clr),
    .dm_a(dm_a), .dm_wd(dm_wd), .dm_we(dm_we), .dm_pc(dm_pc), .dm_rd(dm_rd),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data), .wb_pc(wb_pc),
    .err_valid(err_valid), .err_pc(err_pc), .err_badaddr(err_badaddr),
    .err_store(err_store), .err_count(err_count)
  );

  // clock and memory model
  always #5 clk = ~clk;

  assign dm_rd = mem[dm_a[13:2]];

  always @(posedge clk) begin
    if (dm_we) begin
      mem[dm_a[13:2]] <= dm_wd;
      we_count <= we_count + 1;
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [3:0] op, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [31:0] pc, input logic [4:0] rd);
    req_valid = v;
    req_op    = op;
    req_addr  = addr;
    req_wdata = wdata;
    req_pc    = pc;
    req_rd    = rd;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 32'h0;
    mem[32'h1000 >> 2] = 32'h1122_3344;
    mem[32'h2000 >> 2] = 32'h8000_FF7F;
    reset = 1'b0; stall = 1'b0; flush = 1'b0; err_clr = 1'b0;
    drive(1'b0, MEM_NONE, 32'h0, 32'h0, 32'h0, 5'd0);
    tick();
    tick();
    check("rst_wb_valid", wb_valid, 0);
    check("rst_wb_rd", wb_rd, 0);
    check("rst_wb_data", wb_data, 0);
    check("rst_wb_pc", wb_pc, 0);
    check("rst_err_valid", err_valid, 0);
    check("rst_err_count", err_count, 0);
    check("rst_dm_we", dm_we, 0);
    reset = 1'b1;
    tick();

    // SB merges into byte 2 of the existing word
    drive(1'b1, MEM_SB, 32'h1002, 32'h0000_00AA, 32'h100, 5'd7);
    #2;
    check("sb_dm_we", dm_we, 1);
    check("sb_dm_a", dm_a, 32'h1000);
    check("sb_dm_wd", dm_wd, 32'h11AA_3344);
    check("sb_dm_pc", dm_pc, 32'h100);
    tick();
    drive(1'b0, MEM_NONE, 32'h0, 32'h0, 32'h0, 5'd0);
    check("sb_wb_valid", wb_valid, 1);
    check("sb_wb_rd", wb_rd, 0);
    check("sb_wb_pc", wb_pc, 32'h100);
    tick();
    tick();
    check("sb_we_once", we_count, 1);
    check("sb_mem", mem[32'h1000 >> 2], 32'h11AA_3344);

    // load extraction
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, ld_op[i], ld_addr[i], 32'h0, 32'h1000 + 32'(4 * i), 5'(i + 1));
      #2;
      check("ld_dm_we", dm_we, 0);
      tick();
      check("ld_wb_data", wb_data, ld_exp[i]);
      check("ld_wb_rd", wb_rd, 32'(i + 1));
      check("ld_wb_pc", wb_pc, 32'h1000 + 32'(4 * i));
      check("ld_wb_valid", wb_valid, 1);
    end

    // stalled SW: no write and frozen MEM/WB until release
    drive(1'b1, MEM_SW, 32'h3000, 32'hDEAD_BEEF, 32'h200, 5'd3);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #2;
      check("stall_dm_we", dm_we, 0);
      tick();
      check("stall_wb_pc", wb_pc, 32'h101C);
      check("stall_wb_data", wb_data, 32'h80);
      check("stall_wb_rd", wb_rd, 8);
    end
    stall = 1'b0;
    #2;
    check("rel_dm_we", dm_we, 1);
    check("rel_dm_wd", dm_wd, 32'hDEAD_BEEF);
    tick();
    check("rel_wb_pc", wb_pc, 32'h200);
    check("rel_wb_rd", wb_rd, 0);
    check("rel_wb_data", wb_data, 0);
    check("rel_we_count", we_count, 2);
    check("rel_mem", mem[32'h3000 >> 2], 32'hDEAD_BEEF);

    // misaligned LW then out-of-range SH: first fault wins
    drive(1'b1, MEM_LW, 32'h1002, 32'h0, 32'h3010, 5'd5);
    #2;
    check("flw_dm_we", dm_we, 0);
    tick();
    check("flw_wb_rd", wb_rd, 0);
    check("flw_wb_valid", wb_valid, 1);
    check("flw_err_valid", err_valid, 1);
    check("flw_err_count", err_count, 1);
    drive(1'b1, MEM_SH, 32'h0040_0000, 32'h1234, 32'h3014, 5'd6);
    #2;
    check("fsh_dm_we", dm_we, 0);
    tick();
    check("fsh_err_valid", err_valid, 1);
    check("fsh_err_pc", err_pc, 32'h3010);
    check("fsh_err_badaddr", err_badaddr, 32'h1002);
    check("fsh_err_store", err_store, 0);
    check("fsh_err_count", err_count, 2);
    check("fsh_wb_rd", wb_rd, 0);
    check("fsh_we_count", we_count, 2);

    // err_clr with a simultaneous fault relatches the new fault
    drive(1'b1, MEM_SB, 32'h0050_0000, 32'h77, 32'h4000, 5'd0);
    err_clr = 1'b1;
    #2;
    check("clr_dm_we", dm_we, 0);
    tick();
    check("clr_err_valid", err_valid, 1);
    check("clr_err_pc", err_pc, 32'h4000);
    check("clr_err_badaddr", err_badaddr, 32'h0050_0000);
    check("clr_err_store", err_store, 1);
    check("clr_err_count", err_count, 3);
    drive(1'b0, MEM_NONE, 32'h0, 32'h0, 32'h0, 5'd0);
    tick();
    err_clr = 1'b0;
    check("clr_only_err_valid", err_valid, 0);
    check("clr_only_err_count", err_count, 3);

    // flushed (faulting) LW: bubble, fault not counted
    drive(1'b1, MEM_LW, 32'h1001, 32'h0, 32'h5000, 5'd9);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("fl_wb_valid", wb_valid, 0);
    check("fl_wb_rd", wb_rd, 0);
    check("fl_wb_data", wb_data, 0);
    check("fl_wb_pc", wb_pc, 32'h5000);
    check("fl_err_count", err_count, 3);
    check("fl_err_valid", err_valid, 0);

    drive(1'b1, MEM_LW, 32'h1000, 32'h0, 32'h5004, 5'd9);
    tick();
    check("lw_wb_data", wb_data, 32'h11AA_3344);
    check("lw_wb_rd", wb_rd, 9);

    // reset during a store: no write, everything back to reset values
    drive(1'b1, MEM_SW, 32'h1000, 32'h55, 32'h5008, 5'd0);
    reset = 1'b0;
    #2;
    check("rstw_dm_we", dm_we, 0);
    tick();
    check("rstw_wb_valid", wb_valid, 0);
    check("rstw_wb_pc", wb_pc, 0);
    check("rstw_wb_data", wb_data, 0);
    check("rstw_err_count", err_count, 0);
    check("rstw_err_pc", err_pc, 0);
    check("rstw_mem", mem[32'h1000 >> 2], 32'h11AA_3344);
    check("rstw_we_count", we_count, 2);
    reset = 1'b1;

    // counter saturation under a continuous fault stream
    drive(1'b1, MEM_LW, 32'h0000_0001, 32'h0, 32'h6000, 5'd1);
    for (int i = 0; i < 260; i++) tick();
    check("sat_err_count", err_count, 32'hFF);
    check("sat_err_pc", err_pc, 32'h6000);
    check("sat_err_badaddr", err_badaddr, 32'h1);
    drive(1'b0, MEM_NONE, 32'h0, 32'h0, 32'h0, 5'd0);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
